// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: port count, FSM states, latched command record.
// Pure declarations; no logic, no latency, no flow control.
package mem_arbiter_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int ARB_DWIDTH = 8;
  localparam int ARB_AWIDTH = 5;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_AWIDTH-1:0] addr;
    logic [ARB_DWIDTH-1:0] wdata;
    logic                  port;
  } arb_cmd_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    port_onehot       = '0;
    port_onehot[port] = 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of mem_arbiter: per-port req/we/addr/wdata in, gnt/done/rdata/busy out.
// Requesters hold req until their gnt pulse; done follows gnt by one cycle.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DWIDTH = ARB_DWIDTH,
  parameter int AWIDTH = ARB_AWIDTH
);

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*AWIDTH-1:0] req_addr;
  logic [NUM_PORTS*DWIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        done;
  logic [DWIDTH-1:0]           rdata;
  logic                        busy;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, done, rdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational one-hot winner select; round-robin on last-served port when MEM_ARBITER_RR_EN
// is defined, otherwise fixed priority with port 0 winning. Zero latency, no state.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARBITER_RR_EN
  input  logic                 last,
`endif
  output logic [NUM_PORTS-1:0] win
);

`ifdef MEM_ARBITER_RR_EN
  always_comb begin
    win = '0;
    if (req[0] && req[1]) begin
      // the port not served last takes the conflict
      win = last ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end
`else
  always_comb begin
    win = '0;
    if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port tristate memory (MEM_ARBITER_RR_EN selects round-robin).
// gnt one cycle after req, done/rdata one cycle after gnt; one access per two cycles, requests ignored in ACCESS.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DWIDTH = ARB_DWIDTH,
  parameter int AWIDTH = ARB_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              mem_rd,
  output logic              mem_wr
);

  // the latched command record is sized by the package widths
  if (DWIDTH != ARB_DWIDTH || AWIDTH != ARB_AWIDTH) begin : g_width_check
    $error("mem_arbiter: DWIDTH/AWIDTH must match mem_arbiter_pkg");
  end

  arb_state_t           state;
  arb_state_t           state_nxt;
  arb_cmd_t             cmd;
  logic [NUM_PORTS-1:0] win;
  logic [NUM_PORTS-1:0] done_q;
  logic [DWIDTH-1:0]    rdata_q;
  logic                 take;
  logic                 drive;

  assign take = (state == ARB_IDLE) && (|bus.req);

`ifdef MEM_ARBITER_RR_EN
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take) begin
      last <= win[1];
    end
  end

  mem_arb_pick u_pick (
    .req  (bus.req),
    .last (last),
    .win  (win)
  );
`else
  mem_arb_pick u_pick (
    .req (bus.req),
    .win (win)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (|bus.req) state_nxt = ARB_ACCESS;
      ARB_ACCESS: state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt  = '0;
    bus.busy = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    drive    = 1'b0;
    if (state == ARB_ACCESS) begin
      bus.gnt  = port_onehot(cmd.port);
      bus.busy = 1'b1;
      mem_rd   = ~cmd.we;
      mem_wr   = cmd.we;
      drive    = cmd.we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (take) begin
      cmd.we    <= |(bus.req_we & win);
      cmd.port  <= win[1];
      cmd.addr  <= win[1] ? bus.req_addr[AWIDTH +: AWIDTH] : bus.req_addr[0 +: AWIDTH];
      cmd.wdata <= win[1] ? bus.req_wdata[DWIDTH +: DWIDTH] : bus.req_wdata[0 +: DWIDTH];
    end
  end

  // an aborted access (reset in ACCESS) never reaches this register, so no done follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= (state == ARB_ACCESS) ? port_onehot(cmd.port) : '0;
      if (state == ARB_ACCESS && !cmd.we) begin
        rdata_q <= mem_data;
      end
    end
  end

  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign mem_addr  = cmd.addr;

  assign mem_data = drive ? cmd.wdata : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural tristate memory and a done/rdata scoreboard.
// Covers reset, single-port vectors, contention, back-to-back accesses, address wrap, reset mid-write.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  wire  [DW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;

  mem_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr)
  );

  always #5 clk = ~clk;

  // memory: synchronous write, combinational read onto the shared bus
  logic [DW-1:0] mem [32] = '{0: 8'h3C, 3: 8'h11, 7: 8'h77, default: 8'h00};
  assign mem_data = (mem_rd && !mem_wr) ? mem[mem_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          port;
    logic          rd;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  always @(negedge clk) begin : monitor
    sb_t e;
    if (rst_n) chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
    if (bus.done != 2'b00) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_done_port", 32'(bus.done), 32'(e.port ? 2'b10 : 2'b01));
        if (e.rd) chk("sb_rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
  end

  // called at a negedge with the FSM in IDLE; returns at the negedge of the done cycle
  task automatic txn(input vec_t v);
    logic [1:0] oh;
    int         p;
    oh = v.port ? 2'b10 : 2'b01;
    p  = v.port ? 1 : 0;
    bus.req       = oh;
    bus.req_we    = v.we ? oh : 2'b00;
    bus.req_addr  = {2{~v.addr}};
    bus.req_wdata = {2{~v.wdata}};
    bus.req_addr[p*AW +: AW]  = v.addr;
    bus.req_wdata[p*DW +: DW] = v.wdata;
    sb.push_back('{port: v.port, rd: !v.we, rdata: v.exp_rdata});
    @(negedge clk);
    chk("txn_gnt", 32'(bus.gnt), 32'(oh));
    chk("txn_busy", 32'(bus.busy), 32'd1);
    chk("txn_mem_rd", 32'(mem_rd), 32'(!v.we));
    chk("txn_mem_wr", 32'(mem_wr), 32'(v.we));
    chk("txn_mem_addr", 32'(mem_addr), 32'(v.addr));
    chk("txn_mem_data", 32'(mem_data), 32'(v.we ? v.wdata : v.exp_rdata));
    bus.req = 2'b00;
    @(negedge clk);
    chk("txn_done", 32'(bus.done), 32'(oh));
    chk("txn_idle_gnt", 32'(bus.gnt), 32'd0);
    chk("txn_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  vec_t       vecs[8];
  logic [3:0] ord;

  initial begin
    vecs[0] = '{port: 1'b1, we: 1'b1, addr: 5'd5,  wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{port: 1'b0, we: 1'b0, addr: 5'd5,  wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[2] = '{port: 1'b0, we: 1'b1, addr: 5'd31, wdata: 8'hFF, exp_rdata: 8'h00};
    vecs[3] = '{port: 1'b1, we: 1'b0, addr: 5'd31, wdata: 8'h00, exp_rdata: 8'hFF};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[5] = '{port: 1'b0, we: 1'b1, addr: 5'd12, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[6] = '{port: 1'b0, we: 1'b0, addr: 5'd12, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[7] = '{port: 1'b1, we: 1'b0, addr: 5'd3,  wdata: 8'h00, exp_rdata: 8'h11};

    bus.req       = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    #2;
    chk("rst_outs", 32'({bus.gnt, bus.done, bus.busy, mem_rd, mem_wr}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", 32'({bus.gnt, bus.done, bus.busy, mem_rd, mem_wr}), 32'd0);
    end

    // reset asserted in the middle of a write ACCESS
    bus.req       = 2'b10;
    bus.req_we    = 2'b10;
    bus.req_addr  = {5'd9, 5'd0};
    bus.req_wdata = {8'h99, 8'h00};
    @(negedge clk);
    chk("abort_pre_wr", 32'(mem_wr), 32'd1);
    rst_n   = 1'b0;
    bus.req = 2'b00;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_idle", 32'({bus.gnt, bus.done, bus.busy, mem_rd, mem_wr}), 32'd0);
    end

    // both ports read continuously for 8 cycles
`ifdef MEM_ARBITER_RR_EN
    ord = 4'b1010;
`else
    ord = 4'b0000;
`endif
    bus.req      = 2'b11;
    bus.req_we   = 2'b00;
    bus.req_addr = {5'd7, 5'd3};
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{port: ord[k], rd: 1'b1, rdata: ord[k] ? 8'h77 : 8'h11});
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) bus.req = 2'b00;
      if (k % 2 == 1) chk("contend_gnt", 32'(bus.gnt), 32'(ord[(k-1)/2] ? 2'b10 : 2'b01));
      else            chk("contend_gap", 32'(bus.gnt), 32'd0);
    end
    @(negedge clk);
    chk("contend_release", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i]);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
